// File: rtl/imem_loader.sv
// imem_loader: instruction-side responder for the single-cycle core.
//
// Fills an internal word memory at boot from a byte stream with a
// valid/ready handshake. The stream is a 4-byte little-endian word count N
// followed by N little-endian 32-bit words. The core is held in reset until
// the image is loaded, then its fetches are answered combinationally from
// the memory.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all image bytes before the core is released.
//
// Ports:
//   i_clk          clock, all state changes on rising edge
//   i_reset        synchronous active-high reset
//   i_rx_data      load-stream byte
//   i_rx_valid     i_rx_data is valid
//   o_rx_ready     loader accepts a byte this cycle
//   i_pc           fetch byte address from the core
//   o_instruction  instruction word for i_pc (combinational, 0 if out of range)
//   o_core_reset   reset for the core, high until the image is loaded
//   o_loading      high while the stream is being consumed
//   o_error        sticky load-failure flag, cleared only by reset
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instruction,
  output logic        o_core_reset,
  output logic        o_loading,
  output logic        o_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CKSUM, S_RUN, S_ERR} state_t;
  localparam state_t S_DONE = S_CKSUM;
`else
  typedef enum logic [1:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;
  localparam state_t S_DONE = S_RUN;
`endif

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_byteCnt;
  logic [31:0] r_asm;
  // r_count doubles as the write index: words are committed in order
  logic [AW:0] r_count;
  logic [AW:0] r_total;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_wordDone;
  logic        w_lastWord;
  logic [31:0] w_word;
  logic [AW-1:0] w_fetchIdx;
  logic        w_inRange;
  logic        w_unused;

  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_wordDone = w_accept && (r_byteCnt == 2'd3);
  // Little-endian: each new byte enters at the top and older bytes shift down
  assign w_word     = {i_rx_data, r_asm[31:8]};
  assign w_lastWord = ((r_count + (AW+1)'(1)) == r_total);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_xor <= 8'h00;
    end else if (w_accept && r_state == S_DATA) begin
      r_xor <= r_xor ^ i_rx_data;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_LEN: begin
        if (w_wordDone) begin
          if (w_word == 32'd0) begin
            w_nextState = S_DONE;
          end else if (w_word > 32'(DEPTH)) begin
            w_nextState = S_ERR;
          end else begin
            w_nextState = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_wordDone && w_lastWord) begin
          w_nextState = S_DONE;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (w_accept) begin
          w_nextState = (i_rx_data == r_xor) ? S_RUN : S_ERR;
        end
      end
`endif
      default: w_nextState = r_state;
    endcase
  end

  always_comb begin
    o_rx_ready   = 1'b0;
    o_loading    = 1'b0;
    o_core_reset = 1'b1;
    o_error      = 1'b0;
    case (r_state)
      S_LEN, S_DATA: begin
        o_rx_ready = 1'b1;
        o_loading  = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        o_rx_ready = 1'b1;
        o_loading  = 1'b1;
      end
`endif
      S_RUN:   o_core_reset = 1'b0;
      S_ERR:   o_error = 1'b1;
      default: o_core_reset = 1'b1;
    endcase
  end

  // Byte assembly, word counting and the captured length.
  // An oversize count is truncated into r_total, but that path goes to ERR
  // so the truncated value is never used.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_byteCnt <= 2'd0;
      r_asm     <= 32'd0;
      r_count   <= '0;
      r_total   <= '0;
    end else if (w_accept) begin
      r_asm     <= w_word;
      r_byteCnt <= r_byteCnt + 2'd1;
      if (r_state == S_LEN && w_wordDone) begin
        r_total <= w_word[AW:0];
      end
      if (r_state == S_DATA && w_wordDone) begin
        r_count <= r_count + (AW+1)'(1);
      end
    end
  end

  // Memory is never cleared; stale words stay unreachable because fetches
  // are bounded by r_count.
  always_ff @(posedge i_clk) begin
    if (!i_reset && r_state == S_DATA && w_wordDone) begin
      r_mem[r_count[AW-1:0]] <= w_word;
    end
  end

  assign w_fetchIdx    = i_pc[AW+1:2];
  assign w_inRange     = (i_pc[31:AW+2] == '0) && ({1'b0, w_fetchIdx} < r_count);
  assign o_instruction = (r_state == S_RUN && w_inRange) ? r_mem[w_fetchIdx] : 32'h0;

  assign w_unused = ^{i_pc[1:0], r_asm[7:0]};

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-side responder for the single-cycle core. Answers the core's fetch requests (`pc` in, `instruction` out) from an internal word memory. Fills that memory at boot from a byte stream with a valid/ready handshake. Holds the core in reset until the image is fully loaded.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory size in 32-bit words; power of two, 4..65536.
- `AW`, $clog2(DEPTH): word-index width (derived; do not override).

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `reset`  input  1: synchronous, active-high.
- `rx_data`  input  8: load-stream byte.
- `rx_valid`  input  1: `rx_data` valid.
- `rx_ready`  output  1: loader accepts a byte this cycle.
- `pc`  input  32: fetch byte address from the core.
- `instruction`  output  32: instruction word for `pc` (combinational).
- `core_reset`  output  1: active-high reset for the core; high until the image is loaded.
- `loading`  output  1: high in states LEN and DATA (and CKSUM when compiled in).
- `error`  output  1: sticky load-failure flag.

## Operation
- **Byte accept:** a byte is accepted when `rx_valid && rx_ready` at a rising edge.
- **Stream format:**
  - 4-byte word count N, little-endian.
  - Then 4·N image bytes, each word little-endian; word k lands at index k.
- **Word assembly:** image bytes shift into a 32-bit assembly register; the 4th byte of each word writes `mem[widx]`, then `widx` increments.
- **State machine:**
  - **LEN:** collect 4 count bytes.
    - N == 0 → RUN.
    - N > DEPTH → ERR.
    - Otherwise → DATA.
  - **DATA:** collect 4·N bytes; after the last one → RUN (or → CKSUM when configured).
  - **RUN:** `rx_ready` = 0; `core_reset` = 0; serve fetches.
  - **ERR:** `rx_ready` = 0; `core_reset` = 1; `error` = 1; exit only via `reset`.
- **Signal decode:**
  - `rx_ready` = 1 in LEN, DATA, CKSUM.
  - `core_reset` = (state != RUN).
- **Fetch:**
  - idx = `pc[AW+1:2]`; `pc[1:0]` ignored.
  - Out-of-range: if `pc[31:AW+2]` != 0 or idx >= `count`, `instruction` = 32'h0 (NOP).
  - Otherwise `instruction` = `mem[idx]`.
  - Outside RUN, `instruction` = 0.
- **`count`:** number of words written during this load. It increments with each committed word, so it equals N in RUN.
- **Reset:**
  - State → LEN; byte counter, `widx`, `count`, assembly register → 0; `error` → 0.
  - Memory contents are not cleared. They are unreachable because `count` = 0.
  - Reset mid-load discards the partial image; the next byte is count byte 0.
- **Input hold:** `rx_valid` low stalls the loader indefinitely with no timeout. Bytes presented in RUN/ERR are not accepted.

## Timing
- **Reset values:**
  - `rx_ready` = 1, `core_reset` = 1, `loading` = 1, `error` = 0, `instruction` = 0.
  - These hold from the first edge with `reset` high through the cycle after `reset` drops, while state is LEN.
- **Throughput:** one byte per cycle at full rate. Loading N words takes 4 + 4N accepted bytes (+1 with checksum).
- **Write visibility:** a word written at edge t is readable combinationally from cycle t+1.
- **Final-byte edge:** state → RUN at the edge accepting the final byte. `core_reset` falls in the following cycle; the core's first fetch (pc = 0) sees the full image.
- **Entering ERR:** happens at the edge accepting count byte 3 (or the checksum byte). `error` rises in the next cycle.
- **`reset` precedence:** `reset` overrides any simultaneous byte acceptance.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- **When defined:**
  - An extra state CKSUM follows DATA. It is also entered when N == 0.
  - The loader accepts one byte. It must equal the XOR of all 4·N image bytes; the count bytes are excluded, and N == 0 gives 8'h00.
  - Match → RUN; mismatch → ERR.
  - `count` is still updated during DATA, but fetches return 0 until RUN.
- **When undefined:** no CKSUM state, no XOR register; the stream ends after the last image byte.

## Test plan
1. **Normal load:** reset, then stream 02 00 00 00, 05 00 01 20, 2A 00 00 00 → `core_reset` low the cycle after the 12th byte; pc=0 → 32'h20010005; pc=4 → 32'h0000002A; pc=6 → 32'h0000002A; pc=8 → 0.
2. **Backpressure gaps:** same stream with random `rx_valid` gaps of 0–5 cycles → identical memory contents, `rx_ready` high throughout the load, `core_reset` low only after the last byte.
3. **Oversize count:** N = DEPTH+1 (DEPTH=256: 01 01 00 00) → `error` = 1, `rx_ready` = 0, `core_reset` stays 1; `reset` then recovers to LEN with `error` = 0.
4. **Mid-load reset:** reset after 6 bytes, then stream 01 00 00 00, EF BE AD DE → pc=0 → 32'hDEADBEEF; pc=4 → 0.
5. **Empty image:** stream 00 00 00 00 → RUN immediately; all fetches return 0. With `IMEM_LOADER_CHECKSUM_EN`, the loader additionally waits for the 00 checksum byte.
6. **Checksum (with `IMEM_LOADER_CHECKSUM_EN`):** test 1 stream + checksum 8'h0E → RUN; checksum 8'h0F → ERR, `core_reset` stays 1.
